sub_div_seq: RTL and testbench



---
 rtl/sub_div_pkg.sv | 14 +
 rtl/sub_div_seq_if.sv | 30 +++
 rtl/sub_div_seq_sub.sv | 26 ++
 rtl/sub_div_seq.sv | 107 ++++++++++
 tb/tb_sub_div_seq.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sub_div_pkg.sv
// Shared types and constants for the sub_div_seq restoring divider.
// The optional SUB_DIV_DBZ_FAST_EN build macro is consumed in rtl/sub_div_seq.sv.
package sub_div_pkg;

    localparam int SUB_DIV_WIDTH = 16;
    localparam int SUB_DIV_CNT_W = $clog2(SUB_DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sub_div_seq_if.sv
// Operand/result handshake bundle between the execute stage (master) and the
// divider (slave).
interface sub_div_seq_if
    import sub_div_pkg::*;
#(
    parameter int N = SUB_DIV_WIDTH
);

    logic         start_valid;
    logic         start_ready;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;
    logic         busy;

    modport master (
        output start_valid, dividend, divisor, res_ready,
        input  start_ready, res_valid, quotient, remainder, div_by_zero, busy
    );

    modport slave (
        input  start_valid, dividend, divisor, res_ready,
        output start_ready, res_valid, quotient, remainder, div_by_zero, busy
    );

endinterface

// File: rtl/sub_div_seq_sub.sv
// sub_nbit: parameterised ripple-borrow subtractor, diff = a - b - borrow_in.
// The single piece of arithmetic shared by every step of the divider.
module sub_nbit #(
    parameter int W = 17
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         borrow_in,
    output logic [W-1:0] diff,
    output logic         borrow_out
);

    logic br;

    // Borrow ripples LSB to MSB through a full-subtractor cell per bit.
    always_comb begin
        diff = '0;
        br   = borrow_in;
        for (int i = 0; i < W; i++) begin
            diff[i] = a[i] ^ b[i] ^ br;
            br      = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
        end
        borrow_out = br;
    end

endmodule

// File: rtl/sub_div_seq.sv
// Multi-cycle unsigned restoring divider, one subtract-and-restore step per clock.
// Define SUB_DIV_DBZ_FAST_EN to short-circuit a zero divisor straight to DONE.
module sub_div_seq
    import sub_div_pkg::*;
#(
    parameter int N = SUB_DIV_WIDTH
) (
    input logic            clk,
    input logic            rst_n,
    sub_div_seq_if.slave   bus
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_e        state_q, state_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dbz_q, dbz_d;

    logic [N:0]    p_w;
    logic [N:0]    diff_w;
    logic          borrow_w;
    logic          last_step;

    assign p_w = {rem_q, q_q[N-1]};

    sub_nbit #(.W(N + 1)) u_sub (
        .a          (p_w),
        .b          ({1'b0, dvs_q}),
        .borrow_in  (1'b0),
        .diff       (diff_w),
        .borrow_out (borrow_w)
    );

    // Compared as count+1 == N so the step bound needs no subtraction.
    assign last_step = (({1'b0, cnt_q} + (CW + 1)'(1)) == (CW + 1)'(N));

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    dvs_d   = bus.divisor;
                    q_d     = bus.dividend;
                    rem_d   = '0;
                    cnt_d   = '0;
                    dbz_d   = (bus.divisor == '0);
                    state_d = CALC;
`ifdef SUB_DIV_DBZ_FAST_EN
                    if (bus.divisor == '0) begin
                        q_d     = '1;
                        rem_d   = bus.dividend;
                        state_d = DONE;
                    end
`endif
                end
            end
            CALC: begin
                rem_d = borrow_w ? p_w[N-1:0] : diff_w[N-1:0];
                q_d   = {q_q[N-2:0], ~borrow_w};
                cnt_d = cnt_q + CW'(1);
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.res_valid   = (state_q == DONE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.quotient    = q_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_sub_div_seq.sv
// Self-checking bench for sub_div_seq: directed cases, back-pressure, reset
// mid-operation and randomized operands against a plain-arithmetic model.
module tb_sub_div_seq;

    localparam int N = 16;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    sub_div_seq_if #(.N(N)) bus ();

    sub_div_seq #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what a divide must return, independent of how it is built.
    function automatic logic [N-1:0] ref_q(input logic [N-1:0] a, input logic [N-1:0] b);
        return (b == '0) ? {N{1'b1}} : a / b;
    endfunction

    function automatic logic [N-1:0] ref_r(input logic [N-1:0] a, input logic [N-1:0] b);
        return (b == '0) ? a : a % b;
    endfunction

    // Clock edges from the start handshake until res_valid is seen.
    function automatic int ref_lat(input logic [N-1:0] b);
`ifdef SUB_DIV_DBZ_FAST_EN
        if (b == '0) return 0;
`endif
        return N;
    endfunction

    task automatic start_op(input logic [N-1:0] dvd, input logic [N-1:0] dvs,
                            output int lat, output bit timeout);
        int guard;
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.dividend    = dvd;
        bus.divisor     = dvs;
        guard = 0;
        while (!bus.start_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        lat     = 0;
        timeout = (guard >= 50);
        while (!bus.res_valid && !timeout) begin
            if (lat > 40) begin
                timeout = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
    endtask

    task automatic finish_op();
        @(negedge clk);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero, bus.res_valid, bus.busy} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got q=%h r=%h z=%b v=%b busy=%b expected all zero",
                     bus.quotient, bus.remainder, bus.div_by_zero, bus.res_valid, bus.busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (bus.start_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_start_ready: got %b expected 1", bus.start_ready);
        end
    endtask

    task automatic test_directed();
        logic [N-1:0] dvd [4] = '{16'd100, 16'hFFFF, 16'd3, 16'h1234};
        logic [N-1:0] dvs [4] = '{16'd7, 16'd1, 16'd10, 16'd0};
        logic [N-1:0] eq  [4] = '{16'd14, 16'hFFFF, 16'd0, 16'hFFFF};
        logic [N-1:0] er  [4] = '{16'd2, 16'd0, 16'd3, 16'h1234};
        logic         ez  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int lat;
        bit to;
        for (int i = 0; i < 4; i++) begin
            start_op(dvd[i], dvs[i], lat, to);
            total++;
            if (to || lat !== ref_lat(dvs[i])) begin
                bad++;
                $display("[TB] FAIL directed%0d_latency: got %0d edges (timeout=%b) expected %0d",
                         i, lat, to, ref_lat(dvs[i]));
            end
            total++;
            if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {eq[i], er[i], ez[i]}) begin
                bad++;
                $display("[TB] FAIL directed%0d_result: got q=%h r=%h z=%b expected q=%h r=%h z=%b",
                         i, bus.quotient, bus.remainder, bus.div_by_zero, eq[i], er[i], ez[i]);
            end
            finish_op();
            total++;
            if (bus.res_valid !== 1'b0 || bus.start_ready !== 1'b1) begin
                bad++;
                $display("[TB] FAIL directed%0d_release: got v=%b rdy=%b expected v=0 rdy=1",
                         i, bus.res_valid, bus.start_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] eq;
        logic [N-1:0] er;
        int guard;
        eq = ref_q(16'd50000, 16'd123);
        er = ref_r(16'd50000, 16'd123);
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.dividend    = 16'd50000;
        bus.divisor     = 16'd123;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        repeat (3) @(negedge clk);
        bus.start_valid = 1'b1;
        bus.dividend    = 16'd1;
        bus.divisor     = 16'd1;
        total++;
        if (bus.start_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bp_ready_in_calc: got %b expected 0", bus.start_ready);
        end
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        guard = 0;
        while (!bus.res_valid && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        total++;
        if (bus.res_valid !== 1'b1 || {bus.quotient, bus.remainder, bus.div_by_zero} !== {eq, er, 1'b0}) begin
            bad++;
            $display("[TB] FAIL bp_result: got v=%b q=%h r=%h z=%b expected v=1 q=%h r=%h z=0",
                     bus.res_valid, bus.quotient, bus.remainder, bus.div_by_zero, eq, er);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            total++;
            if ({bus.res_valid, bus.start_ready, bus.quotient, bus.remainder, bus.div_by_zero}
                !== {1'b1, 1'b0, eq, er, 1'b0}) begin
                bad++;
                $display("[TB] FAIL bp_hold%0d: got v=%b rdy=%b q=%h r=%h z=%b expected v=1 rdy=0 q=%h r=%h z=0",
                         c, bus.res_valid, bus.start_ready, bus.quotient, bus.remainder,
                         bus.div_by_zero, eq, er);
            end
        end
        finish_op();
        total++;
        if ({bus.res_valid, bus.start_ready, bus.busy} !== 3'b010) begin
            bad++;
            $display("[TB] FAIL bp_release: got v=%b rdy=%b busy=%b expected 0 1 0",
                     bus.res_valid, bus.start_ready, bus.busy);
        end
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bp_no_queue: got busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        bit to;
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.dividend    = 16'd100;
        bus.divisor     = 16'd7;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero, bus.res_valid, bus.busy} !== '0) begin
            bad++;
            $display("[TB] FAIL midreset_outputs: got q=%h r=%h z=%b v=%b busy=%b expected all zero",
                     bus.quotient, bus.remainder, bus.div_by_zero, bus.res_valid, bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (bus.start_ready !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midreset_idle: got rdy=%b busy=%b expected 1 0", bus.start_ready, bus.busy);
        end
        start_op(16'd100, 16'd7, lat, to);
        total++;
        if (to || {bus.quotient, bus.remainder, bus.div_by_zero} !== {16'd14, 16'd2, 1'b0}) begin
            bad++;
            $display("[TB] FAIL midreset_rerun: got q=%h r=%h z=%b timeout=%b expected q=000e r=0002 z=0",
                     bus.quotient, bus.remainder, bus.div_by_zero, to);
        end
        finish_op();
    endtask

    task automatic test_random();
        logic [N-1:0] a;
        logic [N-1:0] b;
        int lat;
        bit to;
        for (int i = 0; i < 30; i++) begin
            a = N'($urandom);
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = N'($urandom_range(1, 15));
                default: b = N'($urandom);
            endcase
            start_op(a, b, lat, to);
            total++;
            if (to || lat !== ref_lat(b)
                || {bus.quotient, bus.remainder, bus.div_by_zero} !== {ref_q(a, b), ref_r(a, b), (b == '0)}) begin
                bad++;
                $display("[TB] FAIL random%0d %h/%h: got q=%h r=%h z=%b lat=%0d to=%b expected q=%h r=%h z=%b lat=%0d",
                         i, a, b, bus.quotient, bus.remainder, bus.div_by_zero, lat, to,
                         ref_q(a, b), ref_r(a, b), (b == '0), ref_lat(b));
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            finish_op();
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] a;
        logic [N-1:0] b;
        int lat;
        bit to;
        for (int i = 0; i < 3; i++) begin
            a = N'($urandom);
            b = N'($urandom_range(1, 300));
            start_op(a, b, lat, to);
            total++;
            if (to || {bus.quotient, bus.remainder} !== {ref_q(a, b), ref_r(a, b)}) begin
                bad++;
                $display("[TB] FAIL b2b%0d %h/%h: got q=%h r=%h to=%b expected q=%h r=%h",
                         i, a, b, bus.quotient, bus.remainder, to, ref_q(a, b), ref_r(a, b));
            end
            finish_op();
            total++;
            if (bus.start_ready !== 1'b1) begin
                bad++;
                $display("[TB] FAIL b2b%0d_ready: got %b expected 1", i, bus.start_ready);
            end
        end
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        rst_n           = 1'b0;
        bus.start_valid = 1'b0;
        bus.dividend    = '0;
        bus.divisor     = '0;
        bus.res_ready   = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_calc();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
